// File: rtl/flex_sr_pkg.sv
// Shared types and helpers for the serial-to-parallel framer.
package flex_sr_pkg;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/flex_bit_counter.sv
// Modulo-NUM_BITS bit counter with a combinational rollover pulse on the wrapping increment.
module flex_bit_counter
    import flex_sr_pkg::*;
#(
    parameter  int NUM_BITS = 8,
    localparam int CNT_W    = cnt_width(NUM_BITS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    output logic [CNT_W-1:0] count,
    output logic             rollover_pulse
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BITS - 1);

    assign rollover_pulse = count_enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            count <= rollover_pulse ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/flex_stp_framer.sv
// Serial-to-parallel shifter that frames every NUM_BITS bits into a one-entry
// valid/ready holding register with a sticky overrun flag.
module flex_stp_framer
    import flex_sr_pkg::*;
#(
    parameter  int NUM_BITS  = 8,
    parameter  int SHIFT_MSB = 1,
    localparam int CNT_W     = cnt_width(NUM_BITS)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                shift_enable,
    input  logic                serial_in,
    input  logic                word_ready,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic [NUM_BITS-1:0] word_out,
    output logic                word_valid,
    output logic [CNT_W-1:0]    bit_count,
    output logic                overrun
);

    hold_state_t         state;
    hold_state_t         state_nxt;
    logic                word_done;
    logic                load_word;
    logic                drop_word;
    logic [NUM_BITS-1:0] next_sr;

    flex_bit_counter #(
        .NUM_BITS (NUM_BITS)
    ) u_bit_counter (
        .clk            (clk),
        .n_rst          (n_rst),
        .clear          (clear),
        .count_enable   (shift_enable),
        .count          (bit_count),
        .rollover_pulse (word_done)
    );

    generate
        if (SHIFT_MSB != 0) begin : g_shift_msb
            assign next_sr = {parallel_out[NUM_BITS-2:0], serial_in};
        end else begin : g_shift_lsb
            assign next_sr = {serial_in, parallel_out[NUM_BITS-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= HOLD_EMPTY;
        end else if (clear) begin
            state <= HOLD_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A consume and a completion in the same cycle refill the register without loss.
    always_comb begin
        state_nxt = state;
        load_word = 1'b0;
        drop_word = 1'b0;
        case (state)
            HOLD_EMPTY: begin
                if (word_done) begin
                    load_word = 1'b1;
                    state_nxt = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                if (word_done) begin
                    if (word_ready) begin
                        load_word = 1'b1;
                    end else begin
                        drop_word = 1'b1;
                    end
                end else if (word_ready) begin
                    state_nxt = HOLD_EMPTY;
                end
            end
        endcase
    end

    // Clear flushes framing state but leaves the last delivered word visible.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            parallel_out <= '1;
            word_out     <= '1;
            overrun      <= 1'b0;
        end else if (clear) begin
            parallel_out <= '1;
            overrun      <= 1'b0;
        end else begin
            if (shift_enable) begin
                parallel_out <= next_sr;
            end
            if (load_word) begin
                word_out <= next_sr;
            end
            if (drop_word) begin
                overrun <= 1'b1;
            end
        end
    end

    assign word_valid = (state == HOLD_FULL);

endmodule

// File: tb/tb_flex_stp_framer.sv
// Bench driving three framer configurations in lockstep against a word-level reference model.
module tb_flex_stp_framer;

    logic clk;
    logic n_rst;
    logic clear;
    logic shift_enable;
    logic serial_in;
    logic word_ready;

    logic [7:0] po0, wd0, po1, wd1;
    logic [1:0] po2, wd2;
    logic [2:0] cnt0, cnt1;
    logic [0:0] cnt2;
    logic       v0, v1, v2, ov0, ov1, ov2;

    int compared;
    int mismatched;

    // reference state per instance: 0 = (8, MSB-first), 1 = (8, LSB-first), 2 = (2, LSB-first)
    int m_sr [3];
    int m_wd [3];
    int m_v  [3];
    int m_c  [3];
    int m_o  [3];

    flex_stp_framer #(.NUM_BITS(8), .SHIFT_MSB(1)) u_msb (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .word_ready(word_ready), .parallel_out(po0),
        .word_out(wd0), .word_valid(v0), .bit_count(cnt0), .overrun(ov0)
    );

    flex_stp_framer #(.NUM_BITS(8), .SHIFT_MSB(0)) u_lsb (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .word_ready(word_ready), .parallel_out(po1),
        .word_out(wd1), .word_valid(v1), .bit_count(cnt1), .overrun(ov1)
    );

    flex_stp_framer #(.NUM_BITS(2), .SHIFT_MSB(0)) u_n2 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .word_ready(word_ready), .parallel_out(po2),
        .word_out(wd2), .word_valid(v2), .bit_count(cnt2), .overrun(ov2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nbits(input int i);
        return (i == 2) ? 2 : 8;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level rules: bits accumulate until N have arrived, then the word is
    // offered to a single-slot mailbox that drops it (and flags) if still occupied.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int n, mask, nxt, done, free_slot;
            n    = nbits(i);
            mask = (1 << n) - 1;
            if (!n_rst) begin
                m_sr[i] = mask; m_wd[i] = mask; m_v[i] = 0; m_c[i] = 0; m_o[i] = 0;
            end else if (clear) begin
                m_sr[i] = mask; m_v[i] = 0; m_c[i] = 0; m_o[i] = 0;
            end else begin
                if (i == 0) nxt = ((m_sr[i] << 1) | int'(serial_in)) & mask;
                else        nxt = (m_sr[i] >> 1) | (int'(serial_in) << (n - 1));
                done      = (shift_enable && (m_c[i] + 1 == n)) ? 1 : 0;
                free_slot = (m_v[i] == 0 || word_ready) ? 1 : 0;
                if (shift_enable) begin
                    m_sr[i] = nxt;
                    m_c[i]  = (m_c[i] + 1) % n;
                end
                if (done != 0) begin
                    if (free_slot != 0) begin m_wd[i] = nxt; m_v[i] = 1; end
                    else m_o[i] = 1;
                end else if (m_v[i] != 0 && word_ready) begin
                    m_v[i] = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("msb.parallel_out", po0,  m_sr[0]); chk("msb.word_out", wd0, m_wd[0]);
        chk("msb.word_valid",   v0,   m_v[0]);  chk("msb.bit_count", cnt0, m_c[0]);
        chk("msb.overrun",      ov0,  m_o[0]);
        chk("lsb.parallel_out", po1,  m_sr[1]); chk("lsb.word_out", wd1, m_wd[1]);
        chk("lsb.word_valid",   v1,   m_v[1]);  chk("lsb.bit_count", cnt1, m_c[1]);
        chk("lsb.overrun",      ov1,  m_o[1]);
        chk("n2.parallel_out",  po2,  m_sr[2]); chk("n2.word_out", wd2, m_wd[2]);
        chk("n2.word_valid",    v2,   m_v[2]);  chk("n2.bit_count", cnt2, m_c[2]);
        chk("n2.overrun",       ov2,  m_o[2]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_clear();
        clear = 1'b1; shift_enable = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    // shift a byte first-received-bit = b[7]; ready applies to bits 0..6, rdy_last to the 8th
    task automatic shift_byte_msb(input logic [7:0] b, input logic rdy, input logic rdy_last);
        for (int k = 7; k >= 0; k--) begin
            serial_in    = b[k];
            shift_enable = 1'b1;
            word_ready   = (k == 0) ? rdy_last : rdy;
            tick();
        end
        shift_enable = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        compared     = 0;
        mismatched   = 0;
        n_rst        = 1'b0;
        clear        = 1'b0;
        shift_enable = 1'b1;
        serial_in    = 1'b0;
        word_ready   = 1'b0;

        // reset held for two edges while shifting
        tick();
        tick();
        chk("reset.parallel_out", po0, 32'hFF);
        chk("reset.word_out",     wd0, 32'hFF);
        chk("reset.word_valid",   v0,  0);
        chk("reset.bit_count",    cnt0, 0);
        chk("reset.overrun",      ov0, 0);
        #2 n_rst = 1'b1;
        #1;
        chk("reset.midcycle_po", po0, 32'hFF);
        chk("reset.midcycle_cnt", cnt0, 0);
        tick();
        chk("reset.first_shift", po0, 32'hFE);

        // single word, consumer ready
        do_clear();
        shift_byte_msb(8'hA5, 1'b1, 1'b1);
        chk("single.word_out",   wd0, 32'hA5);
        chk("single.word_valid", v0, 1);
        chk("single.bit_count",  cnt0, 0);
        word_ready = 1'b1;
        tick();
        chk("single.consumed", v0, 0);

        // overrun while consumer stalls
        shift_byte_msb(8'hA5, 1'b0, 1'b0);
        shift_byte_msb(8'h3C, 1'b0, 1'b0);
        chk("overrun.word_out",   wd0, 32'hA5);
        chk("overrun.word_valid", v0, 1);
        chk("overrun.flag",       ov0, 1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("overrun.drained", v0, 0);
        chk("overrun.sticky",  ov0, 1);

        // consume and complete on the same edge
        do_clear();
        chk("clear.overrun", ov0, 0);
        shift_byte_msb(8'hA5, 1'b0, 1'b0);
        chk("simul.pre_valid", v0, 1);
        shift_byte_msb(8'h3C, 1'b0, 1'b1);
        chk("simul.word_valid", v0, 1);
        chk("simul.word_out",   wd0, 32'h3C);
        chk("simul.overrun",    ov0, 0);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;

        // gapped shifting then clear
        do_clear();
        pat = 8'b1010_0110;
        for (int k = 0; k < 6; k++) begin
            shift_enable = pat[7-k];
            serial_in    = k[0];
            tick();
        end
        chk("gapped.bit_count", cnt0, 3);
        clear = 1'b1; shift_enable = 1'b1; serial_in = 1'b0;
        tick();
        clear = 1'b0;
        chk("gclear.bit_count",    cnt0, 0);
        chk("gclear.parallel_out", po0, 32'hFF);
        shift_byte_msb(8'h5A, 1'b1, 1'b1);
        chk("gapped.word_out", wd0, 32'h5A);

        // LSB-first instances
        do_clear();
        pat = 8'h1E;
        for (int k = 0; k < 8; k++) begin
            serial_in = pat[k]; shift_enable = 1'b1; word_ready = 1'b0;
            tick();
        end
        shift_enable = 1'b0;
        chk("lsb.word_1E",    wd1, 32'h1E);
        chk("lsb.valid_1E",   v1, 1);
        do_clear();
        chk("n2.cnt_start", cnt2, 0);
        serial_in = 1'b1; shift_enable = 1'b1;
        tick();
        chk("n2.cnt_mid", cnt2, 1);
        serial_in = 1'b0;
        tick();
        shift_enable = 1'b0;
        chk("n2.cnt_wrap", cnt2, 0);
        chk("n2.word_01",  wd2, 32'h1);

        // randomized traffic against the reference model
        for (int k = 0; k < 800; k++) begin
            n_rst        = ($urandom_range(0, 99) != 0);
            clear        = ($urandom_range(0, 47) == 0);
            shift_enable = ($urandom_range(0, 3) != 0);
            serial_in    = 1'($urandom);
            word_ready   = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
